// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage MIPS pipeline: load-use and branch-operand
// stalls, taken-branch/jump flushes, a counted multi-cycle EX freeze, and saturating stall/flush counters.
module hazard_stall_ctrl #(
  parameter int MC_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_id,
  input  logic        id_ex_mem_read,
  input  logic        id_ex_reg_write,
  input  logic [4:0]  id_ex_write_reg,
  input  logic        ex_mem_mem_read,
  input  logic [4:0]  ex_mem_write_reg,
  input  logic        branch_taken_id,
  input  logic        jump_id,
  input  logic        ex_mc_start,
  output logic        pc_enable,
  output logic        if_id_enable,
  output logic        id_ex_enable,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        mc_busy,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  typedef enum logic {RUN = 1'b0, MC_BUSY = 1'b1} state_t;

  localparam logic [3:0] MC_LOAD = 4'(MC_LATENCY - 1);

  state_t     state;
  logic [3:0] mc_cnt;

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       uses_rs;
  logic       uses_rt;
  logic       is_branch;
  logic       rs_hit_ex, rt_hit_ex, rs_hit_mem, rt_hit_mem;
  logic       load_use;
  logic       br_dep;
  logic       hz_stall;
  logic       unused_instr_bits;

  assign opcode            = instr_id[31:26];
  assign rs                = instr_id[25:21];
  assign rt                = instr_id[20:16];
  assign unused_instr_bits = ^instr_id[15:0];

  assign uses_rs   = (opcode != 6'h02) && (opcode != 6'h03);
  assign uses_rt   = (opcode == 6'h00) || (opcode == 6'h04) ||
                     (opcode == 6'h05) || (opcode == 6'h2B);
  assign is_branch = (opcode == 6'h04) || (opcode == 6'h05);

  // Register $0 is hardwired to zero, so it never creates a dependency.
  assign rs_hit_ex  = uses_rs && (rs != 5'd0) && (rs == id_ex_write_reg);
  assign rt_hit_ex  = uses_rt && (rt != 5'd0) && (rt == id_ex_write_reg);
  assign rs_hit_mem = uses_rs && (rs != 5'd0) && (rs == ex_mem_write_reg);
  assign rt_hit_mem = uses_rt && (rt != 5'd0) && (rt == ex_mem_write_reg);

  assign load_use = id_ex_mem_read && (rs_hit_ex || rt_hit_ex);
  assign br_dep   = is_branch &&
                    ((id_ex_reg_write && (rs_hit_ex || rt_hit_ex)) ||
                     (ex_mem_mem_read && (rs_hit_mem || rt_hit_mem)));
  assign hz_stall = load_use || br_dep;

  assign mc_busy = (state == MC_BUSY);

  always_comb begin
    pc_enable    = 1'b1;
    if_id_enable = 1'b1;
    id_ex_enable = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (reset) begin
      if (state == MC_BUSY) begin
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        id_ex_enable = 1'b0;
      end else if (hz_stall) begin
        // A stall outranks a flush: the branch/jump is re-evaluated once operands are ready.
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        id_ex_bubble = 1'b1;
      end else if (branch_taken_id || jump_id) begin
        if_id_flush  = 1'b1;
      end
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      mc_cnt      <= 4'd0;
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      case (state)
        RUN: begin
          if (ex_mc_start) begin
            state  <= MC_BUSY;
            mc_cnt <= MC_LOAD;
          end
        end
        MC_BUSY: begin
          if (mc_cnt == 4'd1) begin
            state  <= RUN;
            mc_cnt <= 4'd0;
          end else begin
            mc_cnt <= mc_cnt - 4'd1;
          end
        end
        default: begin
          state  <= RUN;
          mc_cnt <= 4'd0;
        end
      endcase
      if (!pc_enable && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
      if (if_id_flush && (flush_count != 16'hFFFF))
        flush_count <= flush_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios with literal expectations, then random
// traffic checked every cycle against a dependency-list model of the stall/flush rules.
module tb_hazard_stall_ctrl;

  localparam int MC_LATENCY = 4;
  localparam logic [31:0] ADD_8  = {6'h00, 5'd8, 5'd10, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] ADD_00 = {6'h00, 5'd0, 5'd0, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] BEQ_45 = {6'h04, 5'd4, 5'd5, 16'h0010};

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] instr_id = '0;
  logic        id_ex_mem_read = 0, id_ex_reg_write = 0, ex_mem_mem_read = 0;
  logic [4:0]  id_ex_write_reg = 0, ex_mem_write_reg = 0;
  logic        branch_taken_id = 0, jump_id = 0, ex_mc_start = 0;
  logic        pc_enable, if_id_enable, id_ex_enable, id_ex_bubble, if_id_flush, mc_busy;
  logic [15:0] stall_count, flush_count;

  hazard_stall_ctrl #(.MC_LATENCY(MC_LATENCY)) dut (
    .clk(clk), .reset(reset), .instr_id(instr_id),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write),
    .id_ex_write_reg(id_ex_write_reg), .ex_mem_mem_read(ex_mem_mem_read),
    .ex_mem_write_reg(ex_mem_write_reg), .branch_taken_id(branch_taken_id),
    .jump_id(jump_id), .ex_mc_start(ex_mc_start),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable), .id_ex_enable(id_ex_enable),
    .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush), .mc_busy(mc_busy),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_in(input logic [31:0] ins, input logic ie_mr, input logic ie_rw,
                        input logic [4:0] ie_wr, input logic em_mr, input logic [4:0] em_wr,
                        input logic br, input logic jp, input logic mc);
    instr_id         = ins;
    id_ex_mem_read   = ie_mr;
    id_ex_reg_write  = ie_rw;
    id_ex_write_reg  = ie_wr;
    ex_mem_mem_read  = em_mr;
    ex_mem_write_reg = em_wr;
    branch_taken_id  = br;
    jump_id          = jp;
    ex_mc_start      = mc;
  endtask

  task automatic set_random();
    logic [5:0] ops [8];
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h08};
    instr_id = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 16'($urandom)};
    id_ex_mem_read   = ($urandom_range(0, 2) == 0);
    id_ex_reg_write  = ($urandom_range(0, 1) == 0);
    id_ex_write_reg  = 5'($urandom_range(0, 3));
    ex_mem_mem_read  = ($urandom_range(0, 2) == 0);
    ex_mem_write_reg = 5'($urandom_range(0, 3));
    branch_taken_id  = ($urandom_range(0, 4) == 0);
    jump_id          = ($urandom_range(0, 5) == 0);
    ex_mc_start      = ($urandom_range(0, 39) == 0);
  endtask

  // Model: the instruction's real source registers, checked against each producer in flight.
  function automatic bit hz_model();
    logic [5:0] op;
    logic [4:0] srcs [$];
    bit branch;
    op = instr_id[31:26];
    branch = (op == 6'h04) || (op == 6'h05);
    if (op != 6'h02 && op != 6'h03 && instr_id[25:21] != 0) srcs.push_back(instr_id[25:21]);
    if ((op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2B) && instr_id[20:16] != 0)
      srcs.push_back(instr_id[20:16]);
    foreach (srcs[i]) begin
      if (id_ex_mem_read && srcs[i] == id_ex_write_reg) return 1'b1;
      if (branch && id_ex_reg_write && srcs[i] == id_ex_write_reg) return 1'b1;
      if (branch && ex_mem_mem_read && srcs[i] == ex_mem_write_reg) return 1'b1;
    end
    return 1'b0;
  endfunction

  // scoreboard: model state, expected queue, per-cycle compare
  int m_frozen = 0;
  int m_stall = 0;
  int m_flush = 0;
  logic [5:0] exp_q [$];
  logic [5:0] e;

  always @(posedge clk) begin
    #2;
    if (!reset) begin
      m_frozen = 0;
      m_stall  = 0;
      m_flush  = 0;
      e = 6'b111000;
    end else if (m_frozen > 0) e = 6'b000001;
    else if (hz_model())       e = 6'b001100;
    else if (branch_taken_id || jump_id) e = 6'b111010;
    else                       e = 6'b111000;
    exp_q.push_back(e);
    check("ctrl{pc,ifid,idex,bub,flush,busy}",
          {pc_enable, if_id_enable, id_ex_enable, id_ex_bubble, if_id_flush, mc_busy},
          exp_q.pop_front());
    check("stall_count", stall_count, m_stall);
    check("flush_count", flush_count, m_flush);
    @(negedge clk);
    if (reset) begin
      if (m_frozen > 0) m_frozen--;
      else if (ex_mc_start) m_frozen = MC_LATENCY - 1;
      if (!e[5] && m_stall < 65535) m_stall++;
      if (e[1] && m_flush < 65535) m_flush++;
    end
  end

  initial begin
    set_in('0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 reset = 1'b0;
    // reset holds RUN defaults even with a hazard on the inputs
    @(posedge clk);
    set_in(ADD_8, 1, 1, 8, 0, 0, 1, 1, 1);
    #3;
    check("rst_pc_enable", pc_enable, 1);
    check("rst_flush", if_id_flush, 0);
    check("rst_mc_busy", mc_busy, 0);
    check("rst_stall_count", stall_count, 0);
    @(posedge clk);
    reset = 1'b1;
    set_in('0, 0, 0, 0, 0, 0, 0, 0, 0);

    // load-use: one stall cycle
    @(posedge clk);
    set_in(ADD_8, 1, 1, 8, 0, 0, 0, 0, 0);
    #3;
    check("lu_pc_enable", pc_enable, 0);
    check("lu_bubble", id_ex_bubble, 1);
    @(posedge clk);
    set_in('0, 0, 1, 9, 1, 8, 0, 0, 0);
    #3;
    check("lu_release_pc", pc_enable, 1);
    check("lu_stall_count", stall_count, 1);

    // $0 never creates a hazard
    @(posedge clk);
    set_in(ADD_00, 1, 1, 0, 1, 0, 0, 0, 0);
    #3;
    check("r0_pc_enable", pc_enable, 1);
    @(posedge clk);
    set_in('0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check("r0_stall_count", stall_count, 1);

    // load then dependent branch: two stalls, no flush while stalled
    @(posedge clk);
    set_in(BEQ_45, 1, 1, 4, 0, 0, 1, 0, 0);
    #3;
    check("lb1_pc", pc_enable, 0);
    check("lb1_flush", if_id_flush, 0);
    @(posedge clk);
    set_in(BEQ_45, 0, 0, 0, 1, 4, 1, 0, 0);
    #3;
    check("lb2_pc", pc_enable, 0);
    check("lb2_flush", if_id_flush, 0);
    @(posedge clk);
    set_in(BEQ_45, 0, 0, 0, 0, 0, 1, 0, 0);
    #3;
    check("lb_taken_flush", if_id_flush, 1);
    check("lb_stall_count", stall_count, 3);
    @(posedge clk);
    set_in('0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check("lb_flush_count", flush_count, 1);

    // multi-cycle freeze masks a jump, which then flushes on resume
    @(posedge clk);
    set_in('0, 0, 0, 0, 0, 0, 0, 0, 1);
    #3;
    check("mc_start_busy", mc_busy, 0);
    for (int i = 0; i < MC_LATENCY - 1; i++) begin
      @(posedge clk);
      set_in(ADD_8, 1, 1, 8, 0, 0, 0, 1, (i == 1));
      #3;
      check("mc_busy", mc_busy, 1);
      check("mc_pc_enable", pc_enable, 0);
      check("mc_id_ex_enable", id_ex_enable, 0);
      check("mc_flush", if_id_flush, 0);
    end
    @(posedge clk);
    set_in('0, 0, 0, 0, 0, 0, 0, 1, 0);
    #3;
    check("mc_resume_busy", mc_busy, 0);
    check("mc_resume_flush", if_id_flush, 1);
    check("mc_stall_count", stall_count, 6);
    @(posedge clk);
    set_in('0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check("mc_flush_count", flush_count, 2);

    // reset aborts a freeze immediately
    @(posedge clk);
    ex_mc_start = 1'b1;
    @(posedge clk);
    ex_mc_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", mc_busy, 0);
    check("abort_pc_enable", pc_enable, 1);
    check("abort_stall_count", stall_count, 0);
    check("abort_flush_count", flush_count, 0);
    @(posedge clk);
    reset = 1'b1;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      set_random();
      reset = ($urandom_range(0, 299) != 0);
    end
    @(posedge clk);
    reset = 1'b1;
    set_in('0, 0, 0, 0, 0, 0, 0, 0, 0);

    // saturation of the stall counter
    @(posedge clk);
    set_in(ADD_8, 1, 1, 8, 0, 0, 0, 0, 0);
    repeat (70000) @(posedge clk);
    #3;
    check("sat_stall_count", stall_count, 16'hFFFF);
    @(posedge clk);
    #3;
    check("sat_hold", stall_count, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
